// File: rtl/naxi_mem_slave_responder.sv
// NAXI slave responder: in-order command FIFO, beat-wide backing memory, read/write burst FSM.
// Optional NAXI_WRACK_EN: each completed write returns one rreq acknowledge beat.
module naxi_mem_slave_responder #(
   parameter int NXADDRWIDTH = 34,
   parameter int NXDATAWIDTH = 256,
   parameter int NXIDWIDTH   = 4,
   parameter int NXTYPEWIDTH = 3,
   parameter int NXSIZEWIDTH = 8,
   parameter int NXATTRWIDTH = 3,
   parameter int NUMCFF      = 4,
   parameter int MEMWORDS    = 1024,
   parameter int RDDELY      = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   creq_valid,
   input  logic [NXTYPEWIDTH-1:0] creq_type,
   input  logic [NXATTRWIDTH-1:0] creq_attr,
   input  logic [NXSIZEWIDTH-1:0] creq_size,
   input  logic [NXIDWIDTH-1:0]   creq_id,
   input  logic [NXADDRWIDTH-1:0] creq_addr,
   output logic                   creq_rdstall,
   output logic                   creq_wrstall,
   input  logic                   dreq_valid,
   input  logic [NXIDWIDTH-1:0]   dreq_id,
   input  logic [NXDATAWIDTH-1:0] dreq_data,
   input  logic [NXATTRWIDTH-1:0] dreq_attr,
   output logic                   dreq_stall,
   output logic                   rreq_valid,
   output logic [NXIDWIDTH-1:0]   rreq_id,
   output logic [NXDATAWIDTH-1:0] rreq_data,
   output logic [NXATTRWIDTH-1:0] rreq_attr,
   input  logic                   rreq_stall,
   output logic                   err
);
   localparam int BOFF = $clog2(NXDATAWIDTH / 8);
   localparam int MW   = $clog2(MEMWORDS);
   localparam int PW   = $clog2(NUMCFF);
   localparam int CW   = $clog2(NUMCFF + 1);
   localparam int LW   = (RDDELY > 2) ? $clog2(RDDELY) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RDLAT  = 3'd1;
   localparam logic [2:0] S_RDBEAT = 3'd2;
   localparam logic [2:0] S_WRBEAT = 3'd3;
`ifdef NAXI_WRACK_EN
   localparam logic [2:0] S_WRACK  = 3'd4;
`endif

   typedef struct packed {
      logic                   wr;
      logic [NXSIZEWIDTH-1:0] size;
      logic [NXIDWIDTH-1:0]   id;
      logic [MW-1:0]          baddr;
   } cmd_t;

   logic [NXDATAWIDTH-1:0] mem [MEMWORDS];
   cmd_t                   cff [NUMCFF];
   cmd_t                   head;
   logic [PW-1:0]          wptr, rptr;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic                   stall_q;
   logic [2:0]             state;
   logic [LW-1:0]          lat;
   logic [NXSIZEWIDTH-1:0] beat, cur_size;
   logic [NXIDWIDTH-1:0]   cur_id;
   logic [MW-1:0]          baddr, baddr_nxt;
   logic                   is_rd, is_wr, push, pop, done, take, last;
   logic                   unused_ok;

   assign is_rd     = creq_type == NXTYPEWIDTH'(0);
   assign is_wr     = creq_type == NXTYPEWIDTH'(1);
   assign push      = creq_valid & ~stall_q & (is_rd | is_wr);
   assign take      = rreq_valid & ~rreq_stall;
   assign last      = beat == cur_size;
   assign head      = cff[rptr];
   assign baddr_nxt = baddr + MW'(1);
   assign unused_ok = ^{creq_attr, dreq_attr, creq_addr};

   assign creq_rdstall = stall_q;
   assign creq_wrstall = stall_q;
   assign dreq_stall   = state != S_WRBEAT;

   // The FSM may hand over to the next command in the same cycle a burst finishes.
   always_comb begin
      done = 1'b0;
      case (state)
         S_IDLE:   done = 1'b1;
         S_RDBEAT: done = take & last;
`ifdef NAXI_WRACK_EN
         S_WRACK:  done = take;
`endif
         default:  done = 1'b0;
      endcase
   end

   assign pop     = done & (cnt != '0);
   assign cnt_nxt = cnt + CW'(push) - CW'(pop);

   always_ff @(posedge clk)
      if (push) cff[wptr] <= cmd_t'{wr: is_wr, size: creq_size, id: creq_id, baddr: creq_addr[BOFF +: MW]};

   // Backing memory has no reset so its contents survive rst.
   always_ff @(posedge clk)
      if (!rst && state == S_WRBEAT && dreq_valid) mem[baddr] <= dreq_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         cnt        <= '0;
         stall_q    <= 1'b1;
         state      <= S_IDLE;
         lat        <= '0;
         beat       <= '0;
         cur_size   <= '0;
         cur_id     <= '0;
         baddr      <= '0;
         rreq_valid <= 1'b0;
         rreq_id    <= '0;
         rreq_data  <= '0;
         rreq_attr  <= '0;
         err        <= 1'b0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         cnt     <= cnt_nxt;
         stall_q <= cnt_nxt == CW'(NUMCFF);
         if (creq_valid & ~stall_q & ~is_rd & ~is_wr) err <= 1'b1;

         case (state)
            S_RDLAT:
               if (lat == '0) begin
                  state      <= S_RDBEAT;
                  rreq_valid <= 1'b1;
                  rreq_id    <= cur_id;
                  rreq_data  <= mem[baddr];
                  rreq_attr  <= NXATTRWIDTH'(last);
               end else begin
                  lat <= lat - LW'(1);
               end
            S_RDBEAT:
               if (take) begin
                  if (last) begin
                     rreq_valid <= 1'b0;
                     state      <= S_IDLE;
                  end else begin
                     beat      <= beat + NXSIZEWIDTH'(1);
                     baddr     <= baddr_nxt;
                     rreq_data <= mem[baddr_nxt];
                     rreq_attr <= NXATTRWIDTH'(beat + NXSIZEWIDTH'(1) == cur_size);
                  end
               end
            S_WRBEAT:
               if (dreq_valid) begin
                  if (dreq_id != cur_id) err <= 1'b1;
                  if (last) begin
`ifdef NAXI_WRACK_EN
                     state      <= S_WRACK;
                     rreq_valid <= 1'b1;
                     rreq_id    <= cur_id;
                     rreq_data  <= '0;
                     rreq_attr  <= NXATTRWIDTH'(3'b101);
`else
                     state      <= S_IDLE;
`endif
                  end else begin
                     beat  <= beat + NXSIZEWIDTH'(1);
                     baddr <= baddr_nxt;
                  end
               end
`ifdef NAXI_WRACK_EN
            S_WRACK:
               if (take) begin
                  rreq_valid <= 1'b0;
                  state      <= S_IDLE;
               end
`endif
            default: ;
         endcase

         // Pop overrides the end-of-burst return to IDLE above.
         if (pop) begin
            beat     <= '0;
            cur_size <= head.size;
            cur_id   <= head.id;
            baddr    <= head.baddr;
            if (head.wr) begin
               state <= S_WRBEAT;
            end else if (RDDELY == 1) begin
               state      <= S_RDBEAT;
               rreq_valid <= 1'b1;
               rreq_id    <= head.id;
               rreq_data  <= mem[head.baddr];
               rreq_attr  <= NXATTRWIDTH'(head.size == '0);
            end else begin
               state <= S_RDLAT;
               lat   <= LW'(RDDELY - 2);
            end
         end
      end
   end
endmodule
